// File: rtl/cache_control_if.sv
// Handshake and status bundle between the cache controller, the cache
// datapath, the CPU and physical memory. The controller takes the slave view;
// whoever drives requests and datapath status takes the master view.
interface cache_control_if #(
  parameter int CNT_WIDTH = 16
);
  // CPU side
  logic                 mem_read;
  logic                 mem_write;
  logic                 mem_resp;
  // datapath status
  logic                 is_hit;
  logic                 hit_sel;
  logic                 valid;
  logic                 dirty;
  logic                 lru;
  // array write enables and data bits
  logic                 w_Data_en;
  logic                 w_Tag_en;
  logic                 w_Valid_en;
  logic                 w_Dirty_en;
  logic                 w_LRU_en;
  logic                 Din_LRU;
  logic                 Din_Valid;
  logic                 Din_Dirty;
  // physical memory side
  logic                 pmem_read;
  logic                 pmem_write;
  logic                 pmem_addr_sel;
  logic                 pmem_resp;
  // event counters
  logic [CNT_WIDTH-1:0] hit_count;
  logic [CNT_WIDTH-1:0] miss_count;
  logic [CNT_WIDTH-1:0] wb_count;

  modport master (
    output mem_read, mem_write, is_hit, hit_sel, valid, dirty, lru, pmem_resp,
    input  mem_resp, w_Data_en, w_Tag_en, w_Valid_en, w_Dirty_en, w_LRU_en,
           Din_LRU, Din_Valid, Din_Dirty, pmem_read, pmem_write, pmem_addr_sel,
           hit_count, miss_count, wb_count
  );

  modport slave (
    input  mem_read, mem_write, is_hit, hit_sel, valid, dirty, lru, pmem_resp,
    output mem_resp, w_Data_en, w_Tag_en, w_Valid_en, w_Dirty_en, w_LRU_en,
           Din_LRU, Din_Valid, Din_Dirty, pmem_read, pmem_write, pmem_addr_sel,
           hit_count, miss_count, wb_count
  );
endinterface

// File: rtl/cache_control.sv
// Two-way set-associative cache controller. Mealy FSM (IDLE / WRITEBACK /
// ALLOCATE) that turns datapath status plus CPU and pmem handshakes into array
// write enables and pmem strobes, and keeps wrapping hit/miss/write-back
// counters. The victim way is chosen by the datapath from its LRU bit, so the
// lru status line is carried on the bus for the datapath but not needed here.
module cache_control #(
  parameter int CNT_WIDTH = 16
) (
  input logic           clk,
  input logic           reset,
  cache_control_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITEBACK = 2'd1,
    ALLOCATE  = 2'd2
  } state_t;

  state_t state;
  state_t next_state;

  logic hit;
  logic req;
  logic hit_evt;
  logic miss_evt;
  logic wb_evt;

  // A tag match on an invalid line is a miss.
  assign hit = bus.is_hit & bus.valid;
  assign req = bus.mem_read | bus.mem_write;

  // State register; reset aborts any pmem transaction in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // Next-state: a started pmem transaction always runs to its pmem_resp.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (req && !hit) next_state = bus.dirty ? WRITEBACK : ALLOCATE;
      end
      WRITEBACK: begin
        if (bus.pmem_resp) next_state = ALLOCATE;
      end
      ALLOCATE: begin
        if (bus.pmem_resp) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Outputs and counter events; everything is held at 0 while reset is high.
  always_comb begin
    bus.mem_resp      = 1'b0;
    bus.w_Data_en     = 1'b0;
    bus.w_Tag_en      = 1'b0;
    bus.w_Valid_en    = 1'b0;
    bus.w_Dirty_en    = 1'b0;
    bus.w_LRU_en      = 1'b0;
    bus.Din_LRU       = 1'b0;
    bus.Din_Valid     = 1'b0;
    bus.Din_Dirty     = 1'b0;
    bus.pmem_read     = 1'b0;
    bus.pmem_write    = 1'b0;
    bus.pmem_addr_sel = 1'b0;
    hit_evt           = 1'b0;
    miss_evt          = 1'b0;
    wb_evt            = 1'b0;
    if (!reset) begin
      case (state)
        IDLE: begin
          if (req && hit) begin
            bus.mem_resp = 1'b1;
            bus.w_LRU_en = 1'b1;
            bus.Din_LRU  = ~bus.hit_sel;
            hit_evt      = 1'b1;
            // Write wins over read; the byte merge happens in the datapath.
            if (bus.mem_write) begin
              bus.w_Data_en  = 1'b1;
              bus.w_Dirty_en = 1'b1;
              bus.Din_Dirty  = 1'b1;
            end
          end else if (req) begin
            miss_evt = 1'b1;
          end
        end
        WRITEBACK: begin
          bus.pmem_write    = 1'b1;
          bus.pmem_addr_sel = 1'b1;
          wb_evt            = bus.pmem_resp;
        end
        ALLOCATE: begin
          bus.pmem_read = 1'b1;
          // Fill lands the same cycle pmem_resp arrives; LRU waits for the hit.
          if (bus.pmem_resp) begin
            bus.w_Data_en  = 1'b1;
            bus.w_Tag_en   = 1'b1;
            bus.w_Valid_en = 1'b1;
            bus.Din_Valid  = 1'b1;
            bus.w_Dirty_en = 1'b1;
            bus.Din_Dirty  = 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  // Event counters wrap modulo 2^CNT_WIDTH.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.hit_count  <= '0;
      bus.miss_count <= '0;
      bus.wb_count   <= '0;
    end else begin
      if (hit_evt)  bus.hit_count  <= bus.hit_count  + CNT_WIDTH'(1);
      if (miss_evt) bus.miss_count <= bus.miss_count + CNT_WIDTH'(1);
      if (wb_evt)   bus.wb_count   <= bus.wb_count   + CNT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_cache_control.sv
// Bench for cache_control: emulates a small 4-set two-way cache datapath
// around the controller, a pmem responder with chosen phase lengths, and a
// recency-list cache model that predicts response cycle and counter values.
`timescale 1ns/1ps
module tb_cache_control;
  localparam int CNT_WIDTH = 16;
  localparam int SETS      = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  cache_control_if #(.CNT_WIDTH(CNT_WIDTH)) bus ();
  cache_control #(.CNT_WIDTH(CNT_WIDTH)) dut (.clk(clk), .reset(reset), .bus(bus));

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- datapath emulation ----------------
  logic [1:0] cur_set, cur_tag;
  logic [1:0] dp_tag   [2][SETS];
  logic       dp_valid [2][SETS];
  logic       dp_dirty [2][SETS];
  logic       dp_lru   [SETS];
  logic       dp_init;
  logic       m0, m1, sel, dp_way;

  always_comb begin
    m0 = (dp_tag[0][cur_set] == cur_tag);
    m1 = (dp_tag[1][cur_set] == cur_tag);
    sel = m1 && (dp_valid[1][cur_set] || !m0);
    bus.is_hit  = m0 | m1;
    bus.hit_sel = sel;
    bus.valid   = dp_valid[sel][cur_set];
    bus.lru     = dp_lru[cur_set];
    bus.dirty   = dp_dirty[dp_lru[cur_set]][cur_set];
  end
  assign dp_way = (bus.is_hit && bus.valid) ? bus.hit_sel : dp_lru[cur_set];

  always @(posedge clk) begin
    if (dp_init) begin
      for (int w = 0; w < 2; w++)
        for (int s = 0; s < SETS; s++) begin
          dp_tag[w][s]   <= 2'd0;
          dp_valid[w][s] <= 1'b0;
          dp_dirty[w][s] <= 1'b0;
        end
      for (int s = 0; s < SETS; s++) dp_lru[s] <= 1'b0;
    end else begin
      if (bus.w_Tag_en)   dp_tag[dp_way][cur_set]   <= cur_tag;
      if (bus.w_Valid_en) dp_valid[dp_way][cur_set] <= bus.Din_Valid;
      if (bus.w_Dirty_en) dp_dirty[dp_way][cur_set] <= bus.Din_Dirty;
      if (bus.w_LRU_en)   dp_lru[cur_set]           <= bus.Din_LRU;
    end
  end

  // ---------------- pmem responder ----------------
  // g_wb_len / g_fill_len = number of cycles each strobe is high, resp cycle included.
  int g_wb_len = 1, g_fill_len = 1;
  int ph = 0, ph_cnt = 0;
  logic stray = 1'b0;
  always @(posedge clk) begin
    #1;
    if (stray) begin
      bus.pmem_resp = 1'b1;
    end else if (reset) begin
      bus.pmem_resp = 1'b0; ph = 0; ph_cnt = 0;
    end else if (bus.pmem_write) begin
      if (ph != 1) ph_cnt = 0;
      ph = 1; ph_cnt++;
      bus.pmem_resp = (ph_cnt == g_wb_len);
    end else if (bus.pmem_read) begin
      if (ph != 2) ph_cnt = 0;
      ph = 2; ph_cnt++;
      bus.pmem_resp = (ph_cnt == g_fill_len);
    end else begin
      ph = 0; ph_cnt = 0; bus.pmem_resp = 1'b0;
    end
  end

  // ---------------- reference model ----------------
  // Per set: up to two resident lines, index 0 most recently used.
  int mdl_tag   [SETS][2];
  bit mdl_dirty [SETS][2];
  int mdl_cnt   [SETS];
  int m_hits = 0, m_misses = 0, m_wbs = 0;

  typedef struct {
    int due;
    int hc;
    int mc;
    int wc;
    bit wr;
  } exp_t;
  exp_t sb[$];

  function automatic logic [11:0] out_vec();
    return {bus.mem_resp, bus.w_Data_en, bus.w_Tag_en, bus.w_Valid_en, bus.w_Dirty_en,
            bus.w_LRU_en, bus.Din_LRU, bus.Din_Valid, bus.Din_Dirty, bus.pmem_read,
            bus.pmem_write, bus.pmem_addr_sel};
  endfunction

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (reset === 1'b0) begin
      checks++;
      if ((bus.pmem_read && bus.pmem_write) ||
          ((bus.pmem_read || bus.pmem_write) && (bus.pmem_addr_sel != bus.pmem_write))) begin
        errors++;
        $display("FAIL pmem_strobes got rd=%b wr=%b sel=%b", bus.pmem_read, bus.pmem_write,
                 bus.pmem_addr_sel);
      end
      if (!bus.mem_read && !bus.mem_write) begin
        checks++;
        if (out_vec() != 12'h000) begin
          errors++;
          $display("FAIL idle_quiet got=%03h want=000", out_vec());
        end
      end
      if (bus.pmem_read && bus.pmem_resp) begin
        checks++;
        if ({bus.mem_resp, bus.w_Data_en, bus.w_Tag_en, bus.w_Valid_en, bus.w_Dirty_en,
             bus.w_LRU_en, bus.Din_Valid, bus.Din_Dirty, bus.pmem_write, bus.pmem_addr_sel}
            != 10'b0111101000) begin
          errors++;
          $display("FAIL fill_writes got=%03h (vec incl Din_LRU) want fill enables only", out_vec());
        end
      end
      if (bus.mem_resp) begin
        if (sb.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_resp got mem_resp=1 want none at cycle %0d", cyc);
        end else begin
          exp_t e;
          e = sb.pop_front();
          checks++;
          if (cyc != e.due) begin
            errors++;
            $display("FAIL resp_cycle got=%0d want=%0d", cyc, e.due);
          end
          checks++;
          if (bus.hit_count != CNT_WIDTH'(e.hc) || bus.miss_count != CNT_WIDTH'(e.mc) ||
              bus.wb_count != CNT_WIDTH'(e.wc)) begin
            errors++;
            $display("FAIL resp_counters got h=%0d m=%0d w=%0d want h=%0d m=%0d w=%0d",
                     bus.hit_count, bus.miss_count, bus.wb_count,
                     CNT_WIDTH'(e.hc), CNT_WIDTH'(e.mc), CNT_WIDTH'(e.wc));
          end
          checks++;
          if ({bus.w_LRU_en, bus.w_Data_en, bus.w_Dirty_en, bus.Din_Dirty, bus.w_Tag_en,
               bus.w_Valid_en, bus.pmem_read, bus.pmem_write, bus.Din_LRU}
              != {1'b1, e.wr, e.wr, e.wr, 4'b0000, ~bus.hit_sel}) begin
            errors++;
            $display("FAIL resp_enables got=%03h wr=%b hit_sel=%b", out_vec(), e.wr, bus.hit_sel);
          end
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic issue(input bit wr, input int s, input int t, input int wb_len,
                       input int fill_len, output bit ok);
    int   pos = -1;
    int   lat = 0;
    bit   wb  = 1'b0;
    bit   d;
    exp_t e;
    for (int i = 0; i < mdl_cnt[s]; i++) if (mdl_tag[s][i] == t) pos = i;
    if (pos >= 0) begin
      if (pos == 1) begin
        d = mdl_dirty[s][1];
        mdl_tag[s][1] = mdl_tag[s][0]; mdl_dirty[s][1] = mdl_dirty[s][0];
        mdl_tag[s][0] = t;             mdl_dirty[s][0] = d;
      end
    end else begin
      m_misses++;
      wb = (mdl_cnt[s] == 2) && mdl_dirty[s][1];
      if (wb) m_wbs++;
      lat = 1 + (wb ? wb_len : 0) + fill_len;
      mdl_tag[s][1] = mdl_tag[s][0]; mdl_dirty[s][1] = mdl_dirty[s][0];
      mdl_tag[s][0] = t;             mdl_dirty[s][0] = 1'b0;
      if (mdl_cnt[s] < 2) mdl_cnt[s]++;
    end
    if (wr) mdl_dirty[s][0] = 1'b1;
    e.hc = m_hits; m_hits++;
    e.mc = m_misses; e.wc = m_wbs; e.wr = wr; e.due = cyc + lat;
    sb.push_back(e);
    cur_set = 2'(s); cur_tag = 2'(t);
    g_wb_len = wb_len; g_fill_len = fill_len;
    bus.mem_write = wr;
    bus.mem_read  = wr ? 1'($urandom_range(0, 1)) : 1'b1;
    ok = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (bus.mem_resp) begin ok = 1'b1; break; end
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL resp_timeout got no mem_resp want one within 200 cycles (set %0d tag %0d)", s, t);
    end
    @(posedge clk); #1;
  endtask

  task automatic idle_gap(input int n);
    bus.mem_read = 1'b0; bus.mem_write = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic check_counters(input string name, input int h, input int m, input int w);
    checks++;
    if (bus.hit_count != CNT_WIDTH'(h) || bus.miss_count != CNT_WIDTH'(m) ||
        bus.wb_count != CNT_WIDTH'(w)) begin
      errors++;
      $display("FAIL %s got h=%0d m=%0d w=%0d want h=%0d m=%0d w=%0d", name,
               bus.hit_count, bus.miss_count, bus.wb_count,
               CNT_WIDTH'(h), CNT_WIDTH'(m), CNT_WIDTH'(w));
    end
  endtask

  task automatic run_all();
    bit ok;
    int s, t;
    bit found;
    // Reset with a request pending: everything must stay at 0.
    reset = 1'b1; dp_init = 1'b1;
    cur_set = 2'd0; cur_tag = 2'd0;
    bus.mem_read = 1'b1; bus.mem_write = 1'b0;
    for (int i = 0; i < SETS; i++) mdl_cnt[i] = 0;
    repeat (2) @(posedge clk);
    #1 dp_init = 1'b0;
    @(negedge clk);
    checks++;
    if (out_vec() != 12'h000) begin
      errors++; $display("FAIL reset_outputs got=%03h want=000", out_vec());
    end
    check_counters("reset_counters", 0, 0, 0);
    bus.mem_read = 1'b0;
    @(posedge clk); #1 reset = 1'b0;
    @(posedge clk); #1;

    // Cold read on a stale tag (valid=0): fill held 4 cycles, response at cycle 5.
    issue(1'b0, 0, 0, 1, 4, ok);
    if (!ok) return;
    idle_gap(1);
    check_counters("cold_read_counters", 1, 1, 0);

    // Randomized mix of reads, writes, hits, clean and dirty misses.
    for (int n = 0; n < 300; n++) begin
      issue(1'($urandom_range(0, 1)), $urandom_range(0, SETS - 1), $urandom_range(0, 3),
            $urandom_range(1, 3), $urandom_range(1, 4), ok);
      if (!ok) return;
      idle_gap($urandom_range(0, 2));
    end
    idle_gap(1);
    check_counters("random_counters", m_hits, m_misses, m_wbs);

    // Reset in the middle of a miss, then a stray pmem_resp.
    found = 1'b0;
    for (int i = 0; i < SETS && !found; i++)
      for (int j = 0; j < 4 && !found; j++) begin
        found = 1'b1;
        for (int k = 0; k < mdl_cnt[i]; k++) if (mdl_tag[i][k] == j) found = 1'b0;
        if (found) begin s = i; t = j; end
      end
    cur_set = 2'(s); cur_tag = 2'(t);
    g_wb_len = 1; g_fill_len = 1000;
    bus.mem_read = 1'b1;
    ok = 1'b0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (bus.pmem_read) begin ok = 1'b1; break; end
    end
    checks++;
    if (!ok) begin
      errors++; $display("FAIL alloc_entry got pmem_read=0 want 1 within 50 cycles");
      return;
    end
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    checks++;
    if (out_vec() != 12'h000) begin
      errors++; $display("FAIL async_reset_outputs got=%03h want=000", out_vec());
    end
    check_counters("async_reset_counters", 0, 0, 0);
    bus.mem_read = 1'b0;
    m_hits = 0; m_misses = 0; m_wbs = 0;
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk) stray = 1'b1;
    @(negedge clk);
    checks++;
    if (out_vec() != 12'h000 || bus.pmem_resp !== 1'b1) begin
      errors++; $display("FAIL stray_resp got=%03h resp=%b want=000 resp=1", out_vec(), bus.pmem_resp);
    end
    stray = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;

    // Back in IDLE: a hit on a resident line answers in cycle 0.
    found = 1'b0;
    for (int i = 0; i < SETS && !found; i++)
      if (mdl_cnt[i] > 0) begin found = 1'b1; s = i; t = mdl_tag[i][0]; end
    issue(1'b0, s, t, 1, 1, ok);
    if (!ok) return;
    idle_gap(1);
    check_counters("post_abort_counters", 1, 0, 0);

    // 65536 back-to-back read hits from hit_count=0 wrap the counter to 0.
    reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    m_hits = 0; m_misses = 0; m_wbs = 0;
    for (int n = 0; n < 65536; n++) begin
      issue(1'b0, s, t, 1, 1, ok);
      if (!ok) return;
    end
    idle_gap(1);
    check_counters("hit_wrap", 0, 0, 0);
  endtask

  initial begin
    run_all();
    idle_gap(2);
    checks++;
    if (sb.size() != 0) begin
      errors++; $display("FAIL scoreboard_drain got=%0d pending want=0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
